// File: rtl/decryption_scheduler.sv
// decryption_scheduler: routes one character stream to one of three decryption engines and muxes their outputs back
// Ports:
//   clk, rst_n            clock and synchronous active-high reset (asserted at 1)
//   data_i/valid_i/sel_i  input character, qualifier, engine select (sampled on a message's first character)
//   ready_o               controller accepts characters
//   eng_data_o/eng_valid_o shared engine data bus and one-hot per-engine valid
//   eng_busy_i/eng_data_i/eng_vld_i  engine busy flags, outputs and output valids
//   data_o/valid_o        registered output of the selected engine
//   ovf_o                 sticky: message exceeded MAX_NOF_CHARS
//   err_o                 one-cycle pulse: bad select or watchdog abort
// Optional: define DECRYPTION_SCHEDULER_WATCHDOG_EN to abort WAIT states after TIMEOUT cycles.
module decryption_scheduler #(
    parameter int D_WIDTH = 8,
    parameter int MAX_NOF_CHARS = 50,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [1:0]           sel_i,
    output logic                 ready_o,
    output logic [D_WIDTH-1:0]   eng_data_o,
    output logic [2:0]           eng_valid_o,
    input  logic [2:0]           eng_busy_i,
    input  logic [3*D_WIDTH-1:0] eng_data_i,
    input  logic [2:0]           eng_vld_i,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 ovf_o,
    output logic                 err_o
);
    localparam int CW = $clog2(MAX_NOF_CHARS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_NOF_CHARS);
    typedef enum logic [2:0] {IDLE, ROUTE, DISCARD, WAIT_BUSY, WAIT_DONE} state_t;
    state_t state, state_nx;
    logic [1:0] cur_sel, cur_sel_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic ovf_nx, err_nx, fwd, accept, tok, timeout;
    assign accept = valid_i && ready_o;
    assign tok = (data_i == START_DECRYPTION_TOKEN);
`ifdef DECRYPTION_SCHEDULER_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] wd;
    logic waiting;
    assign waiting = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign timeout = waiting && (wd == TO_LAST);
    // restarts on every state change so each WAIT state gets its own budget
    always_ff @(posedge clk) begin
        if (rst_n || state_nx != state) wd <= '0;
        else if (waiting) wd <= wd + 1'b1;
    end
`else
    logic unused_timeout;
    assign timeout = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif
    always_comb begin
        state_nx = state;
        cur_sel_nx = cur_sel;
        cnt_nx = cnt;
        ovf_nx = ovf_o;
        err_nx = 1'b0;
        fwd = 1'b0;
        case (state)
            IDLE: if (accept && !tok) begin
                if (sel_i != 2'd3) begin
                    cur_sel_nx = sel_i;
                    fwd = 1'b1;
                    cnt_nx = CW'(1);
                    state_nx = ROUTE;
                end else begin
                    err_nx = 1'b1;
                    state_nx = DISCARD;
                end
            end
            ROUTE: if (accept) begin
                if (tok) begin
                    fwd = 1'b1;
                    state_nx = WAIT_BUSY;
                end else if (cnt < MAX_CNT) begin
                    fwd = 1'b1;
                    cnt_nx = cnt + 1'b1;
                end else ovf_nx = 1'b1;
            end
            DISCARD: if (accept && tok) state_nx = IDLE;
            WAIT_BUSY: if (eng_busy_i[cur_sel]) state_nx = WAIT_DONE;
            WAIT_DONE: if (!eng_busy_i[cur_sel]) begin
                state_nx = IDLE;
                cnt_nx = '0;
                ovf_nx = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
        if (timeout) begin
            state_nx = IDLE;
            cnt_nx = '0;
            ovf_nx = 1'b0;
            err_nx = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
            cur_sel <= 2'd0;
            cnt <= '0;
            ovf_o <= 1'b0;
            err_o <= 1'b0;
            ready_o <= 1'b1;
            eng_data_o <= '0;
            eng_valid_o <= 3'b000;
            data_o <= '0;
            valid_o <= 1'b0;
        end else begin
            state <= state_nx;
            cur_sel <= cur_sel_nx;
            cnt <= cnt_nx;
            ovf_o <= ovf_nx;
            err_o <= err_nx;
            ready_o <= !(state_nx inside {WAIT_BUSY, WAIT_DONE});
            eng_data_o <= fwd ? data_i : eng_data_o;
            eng_valid_o <= fwd ? 3'(3'b001 << cur_sel_nx) : 3'b000;
            data_o <= eng_data_i[cur_sel*D_WIDTH +: D_WIDTH];
            valid_o <= eng_vld_i[cur_sel];
        end
    end
endmodule

// File: tb/tb_decryption_scheduler.sv
// tb_decryption_scheduler: randomized self-checking bench for decryption_scheduler
module tb_decryption_scheduler;
    localparam int MAXC = 4;
    localparam logic [7:0] TOKEN = 8'hFA;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [7:0] data_i = '0;
    logic valid_i = 1'b0;
    logic [1:0] sel_i = '0;
    logic ready_o;
    logic [7:0] eng_data_o;
    logic [2:0] eng_valid_o;
    logic [2:0] eng_busy_i = '0;
    logic [23:0] eng_data_i = '0;
    logic [2:0] eng_vld_i = '0;
    logic [7:0] data_o;
    logic valid_o, ovf_o, err_o;
    int n_chk = 0;
    int n_fail = 0;
    int err_cnt = 0;
    logic [10:0] fwd_q[$];
    logic [10:0] exp_q[$];

    decryption_scheduler #(.MAX_NOF_CHARS(MAXC)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .sel_i(sel_i),
        .ready_o(ready_o), .eng_data_o(eng_data_o), .eng_valid_o(eng_valid_o),
        .eng_busy_i(eng_busy_i), .eng_data_i(eng_data_i), .eng_vld_i(eng_vld_i),
        .data_o(data_o), .valid_o(valid_o), .ovf_o(ovf_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (|eng_valid_o) fwd_q.push_back({eng_valid_o, eng_data_o});
        if (err_o) err_cnt++;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected forwards: first min(n,MAXC) characters plus the token, all to the first select; nothing for select 3.
    task automatic send_msg(input logic [1:0] s0, input logic [1:0] s1, input int n, input bit fixed);
        logic [7:0] c;
        int ec0;
        exp_q.delete();
        fwd_q.delete();
        ec0 = err_cnt;
        for (int i = 0; i <= n; i++) begin
            step;
            chk("ready_in_msg", ready_o, 1);
            c = (i == n) ? TOKEN : (fixed ? 8'(8'h41 + i) : 8'($urandom_range(0, 249)));
            valid_i = 1'b1;
            data_i = c;
            sel_i = (i == 0) ? s0 : s1;
            if (s0 != 2'd3 && (i == n || i < MAXC)) exp_q.push_back({3'(3'b001 << s0), c});
        end
        step;
        valid_i = 1'b0;
        step;
        chk("fwd_len", fwd_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < fwd_q.size(); i++) chk("fwd_entry", fwd_q[i], exp_q[i]);
        chk("ready_after_token", ready_o, (s0 == 2'd3) ? 1 : 0);
        chk("ovf_after_token", ovf_o, (s0 != 2'd3 && n > MAXC) ? 1 : 0);
        chk("err_pulses", err_cnt - ec0, (s0 == 2'd3) ? 1 : 0);
        fwd_q.delete();
    endtask

    // Engine k busy for nb cycles, emitting on the first nv; other engines chatter randomly.
    task automatic engine(input int k, input int nb, input int nv, input bit ov);
        logic exp_v;
        logic [7:0] exp_d;
        logic [2:0] b, v;
        exp_v = 1'b0;
        exp_d = '0;
        for (int j = 0; j <= nb; j++) begin
            step;
            if (j > 0) begin
                chk("valid_o", valid_o, exp_v);
                if (exp_v) chk("data_o", data_o, exp_d);
            end
            chk("ready_busy", ready_o, 0);
            chk("ovf_busy", ovf_o, ov);
            if (j < nb) begin
                b = 3'($urandom);
                b[k] = 1'b1;
                v = 3'($urandom);
                v[k] = (j < nv);
                eng_busy_i = b;
                eng_vld_i = v;
                eng_data_i = 24'($urandom);
                exp_v = (j < nv);
                exp_d = eng_data_i[k*8 +: 8];
                valid_i = 1'(j % 2);
                data_i = 8'($urandom);
            end else begin
                eng_busy_i = '0;
                eng_vld_i = '0;
                valid_i = 1'b0;
                exp_v = 1'b0;
            end
        end
        step;
        chk("valid_o_end", valid_o, 0);
        chk("ready_back", ready_o, 1);
        chk("ovf_cleared", ovf_o, 0);
        chk("ignored_fwd", fwd_q.size(), 0);
        chk("eng_data_hold", eng_data_o, TOKEN);
        fwd_q.delete();
    endtask

    initial begin
        int ec0;
        step;
        step;
        chk("rst_ready", ready_o, 1);
        chk("rst_eng_valid", eng_valid_o, 0);
        chk("rst_eng_data", eng_data_o, 0);
        chk("rst_valid_o", valid_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_err", err_o, 0);
        rst_n = 1'b0;
        send_msg(2'd1, 2'd1, 4, 1'b1);
        engine(1, 6, 4, 1'b0);
        send_msg(2'd0, 2'd2, 3, 1'b0);
        engine(0, 4, 3, 1'b0);
        send_msg(2'd3, 2'd0, 3, 1'b0);
        send_msg(2'd2, 2'd2, 2, 1'b0);
        engine(2, 3, 2, 1'b0);
        send_msg(2'd2, 2'd1, 6, 1'b0);
        engine(2, 5, 2, 1'b1);
        for (int m = 0; m < 10; m++) begin
            logic [1:0] s0, s1;
            int n, nb;
            s0 = 2'($urandom_range(0, 3));
            s1 = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 7);
            nb = $urandom_range(1, 6);
            send_msg(s0, s1, n, 1'b0);
            if (s0 != 2'd3) engine(int'(s0), nb, $urandom_range(0, nb), n > MAXC);
        end
        ec0 = err_cnt;
        for (int i = 0; i < 2; i++) begin
            step;
            valid_i = 1'b1;
            data_i = 8'(8'h30 + i);
            sel_i = 2'd1;
        end
        step;
        valid_i = 1'b0;
        eng_data_i = 24'hA5A5A5;
        rst_n = 1'b1;
        step;
        rst_n = 1'b0;
        chk("mid_rst_ready", ready_o, 1);
        chk("mid_rst_eng_valid", eng_valid_o, 0);
        chk("mid_rst_eng_data", eng_data_o, 0);
        chk("mid_rst_data_o", data_o, 0);
        chk("mid_rst_valid_o", valid_o, 0);
        chk("mid_rst_ovf", ovf_o, 0);
        chk("mid_rst_err", err_cnt - ec0, 0);
        send_msg(2'd0, 2'd1, 3, 1'b0);
        engine(0, 2, 1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/decryption_scheduler.md
# decryption_scheduler

- Front-end controller that shares one input character stream between three decryption engines: index 0 Caesar, index 1 Scytale, index 2 ZigZag.
- Per message: latches the engine select, forwards characters and the start-decryption token to that engine only, then waits for the engine's busy cycle to finish before accepting the next message.
- Multiplexes the three engine outputs onto a single registered output port.
- Sits between the character source and the engine instances in the decryption top level.

## Interface
- D_WIDTH, 8, character width
- MAX_NOF_CHARS, 50, max characters per message, token excluded
- START_DECRYPTION_TOKEN, 8'hFA, end-of-message / start-decryption marker
- TIMEOUT, 255, watchdog limit in cycles (only used with the macro)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-high reset (asserted at 1)
- data_i  in  D_WIDTH  input character
- valid_i  in  1  data_i qualifier
- sel_i  in  2  engine select, sampled on the first character of a message
- ready_o  out  1  controller accepts characters
- eng_data_o  out  D_WIDTH  shared data bus to all engines
- eng_valid_o  out  3  one-hot valid, one bit per engine
- eng_busy_i  in  3  busy from each engine
- eng_data_i  in  3*D_WIDTH  engine outputs, engine k at [k*D_WIDTH +: D_WIDTH]
- eng_vld_i  in  3  engine output valids
- data_o  out  D_WIDTH  muxed decrypted character
- valid_o  out  1  data_o qualifier
- ovf_o  out  1  sticky: message exceeded MAX_NOF_CHARS
- err_o  out  1  one-cycle pulse: bad select or watchdog abort

## Operation
- **Reset values:** all outputs 0 except ready_o=1. State IDLE, cur_sel=0, cnt=0.
- **IDLE:**
  - Non-token valid_i with sel_i<3: latch cur_sel, forward the character, cnt=1, go to ROUTE.
  - Non-token valid_i with sel_i==3: err_o pulse, go to DISCARD.
  - Token in IDLE (empty message): ignored; stay in IDLE.
- **ROUTE:**
  - Each valid non-token character is forwarded while cnt<MAX_NOF_CHARS, and cnt increments.
  - If cnt==MAX_NOF_CHARS, the character is dropped and ovf_o is set.
  - On the token: forward it, go to WAIT_BUSY.
  - sel_i is ignored after the first character.
- **DISCARD:** consume characters without forwarding; on the token go to IDLE.
- **WAIT_BUSY:** ready_o=0. When eng_busy_i[cur_sel]=1, go to WAIT_DONE.
- **WAIT_DONE:** ready_o=0. When eng_busy_i[cur_sel]=0, go to IDLE and clear cnt and ovf_o.
- **Ignored input:** valid_i while ready_o=0 is ignored. No data is forwarded and no error is raised.
- **Forward path:** eng_data_o takes data_i and eng_valid_o takes onehot(cur_sel), both registered. eng_data_o holds its value when nothing is forwarded.
- **Return path:** data_o=eng_data_i[cur_sel] and valid_o=eng_vld_i[cur_sel], registered. Valids from non-selected engines are discarded.
- **Counter width:** cnt is wide enough to hold MAX_NOF_CHARS and never wraps.
- **Reset mid-operation:** returns to IDLE within the same edge. Engines are not reset by this block.

## Timing
- Forward latency: 1 cycle. valid_i at edge N gives eng_valid_o at edge N+1, high for exactly one cycle per accepted character.
- Output latency: 1 cycle from eng_vld_i to valid_o.
- Back-to-back characters every cycle are supported in IDLE, ROUTE and DISCARD.
- ready_o is registered and goes low in the cycle after the token is accepted. The token cycle itself is accepted.
- Minimum message turnaround: WAIT_BUSY → WAIT_DONE → IDLE takes at least 2 cycles after the engine raises busy.
- err_o is high for exactly one cycle.

## Configuration
- Macro: DECRYPTION_SCHEDULER_WATCHDOG_EN.
- **Defined:**
  - A cycle counter runs in WAIT_BUSY and WAIT_DONE and restarts on every state entry.
  - When it reaches TIMEOUT, the block pulses err_o, returns to IDLE, and clears cnt and ovf_o.
- **Not defined:** the counter and the TIMEOUT parameter have no effect. WAIT states wait indefinitely.

## Test plan
- **Scytale message:** sel_i=1, characters "ABCD" then 8'hFA, engine model busy for 6 cycles emitting 4 characters → eng_valid_o=3'b010 on 5 cycles, ready_o low until 1 cycle after busy falls, data_o/valid_o mirror engine 1 delayed by 1 cycle.
- **Select latching:** sel_i=0 on the first character, sel_i changes to 2 mid-message → all forwards on eng_valid_o[0]. A concurrent eng_vld_i[2] pulse does not appear on valid_o.
- **Bad select:** sel_i=3, 3 characters plus token → err_o one pulse, eng_valid_o stays 0, ready_o stays 1, next valid message routes normally.
- **Overflow:** MAX_NOF_CHARS=4, 6 characters plus token → 4 characters and the token forwarded, ovf_o=1 until return to IDLE.
- **Ignored input and reset:** valid_i pulses during WAIT_DONE → no eng_valid_o. rst_n=1 for one cycle during ROUTE → next edge all outputs at reset values, ready_o=1.
- **Watchdog (macro defined):** TIMEOUT=10, token sent, engine never raises busy → err_o pulse 10 cycles after WAIT_BUSY entry, ready_o=1 on the next cycle.
